// File: rtl/ahbl_excl_sram_slave_if.sv
// AHB-Lite slave-port bundle with the exclusive-access sideband
// (hexcl/hmaster in, hexokay out). The fabric side uses the master
// modport; the memory responder uses the slave modport.
interface ahbl_excl_sram_slave_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) ();
  logic              ahbls_hready;
  logic              ahbls_hready_resp;
  logic              ahbls_hresp;
  logic [W_ADDR-1:0] ahbls_haddr;
  logic              ahbls_hwrite;
  logic [1:0]        ahbls_htrans;
  logic [2:0]        ahbls_hsize;
  logic [2:0]        ahbls_hburst;
  logic [3:0]        ahbls_hprot;
  logic              ahbls_hmastlock;
  logic [W_DATA-1:0] ahbls_hwdata;
  logic [W_DATA-1:0] ahbls_hrdata;
  logic              ahbls_hexcl;
  logic [7:0]        ahbls_hmaster;
  logic              ahbls_hexokay;

  modport master (
    output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
           ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hwdata,
           ahbls_hexcl, ahbls_hmaster,
    input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata, ahbls_hexokay
  );

  modport slave (
    input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
           ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hwdata,
           ahbls_hexcl, ahbls_hmaster,
    output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata, ahbls_hexokay
  );
endinterface

// File: rtl/ahbl_excl_sram_slave.sv
// AHB-Lite responder in front of a single-port synchronous word RAM, with a
// per-master exclusive reservation monitor for LR/SC style accesses.
// Writes complete with zero wait states; a read that follows a write data
// phase takes one extra stall cycle because the RAM port is busy.
module ahbl_excl_sram_slave #(
  parameter int                W_ADDR    = 32,
  parameter int                W_DATA    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [W_ADDR-1:0] BASE_ADDR = '0,
  parameter int                N_MASTERS = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  ahbl_excl_sram_slave_if.slave ahbls
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [2:0] {IDLE, WDATA, RDATA, RSTALL, ERR1, ERR2} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     word_q;
  logic [3:0]        lanes_q;
  logic              excl_q, legal_q;
  logic [IDW-1:0]    id_q;
  logic              hreadyResp_q, hresp_q, hexokay_q;
  logic              hreadyResp_d, hresp_d, hexokay_d;
  logic [W_DATA-1:0] rdata_q;
  logic [W_DATA-1:0] mem [DEPTH];

  logic [N_MASTERS-1:0] monValid_q, monValid_d;
  logic [AW-1:0]        monWord_q [N_MASTERS];
  logic [AW-1:0]        monWord_d [N_MASTERS];

  logic [W_ADDR-1:0] offset;
  logic [AW-1:0]     wordNew, rdWord;
  logic [3:0]        lanesNew;
  logic              addrErr, legalNew, accept, exclOkNew, rdIssue, commit;
  logic [IDW-1:0]    idNew;

  // Decode the address phase currently on the bus: word, lanes, error, master.
  always_comb begin
    offset   = ahbls.ahbls_haddr - BASE_ADDR;
    wordNew  = offset[AW+1:2];
    lanesNew = 4'b0000;
    case (ahbls.ahbls_hsize)
      3'd0:    lanesNew = 4'b0001 << ahbls.ahbls_haddr[1:0];
      3'd1:    lanesNew = ahbls.ahbls_haddr[1] ? 4'b1100 : 4'b0011;
      3'd2:    lanesNew = 4'b1111;
      default: lanesNew = 4'b0000;
    endcase
    addrErr  = (ahbls.ahbls_hsize > 3'd2)
            || (ahbls.ahbls_hsize == 3'd1 && ahbls.ahbls_haddr[0])
            || (ahbls.ahbls_hsize == 3'd2 && ahbls.ahbls_haddr[1:0] != 2'b00)
            || ((offset >> 2) >= W_ADDR'(DEPTH));
    legalNew = ahbls.ahbls_hmaster < 8'(N_MASTERS);
    idNew    = ahbls.ahbls_hmaster[IDW-1:0];
    accept   = ahbls.ahbls_htrans[1] && ahbls.ahbls_hready
            && (state_q == IDLE || state_q == WDATA || state_q == RDATA || state_q == ERR2);
  end

  // A write data phase commits unless it is an exclusive write that was refused.
  assign commit = (state_q == WDATA) && (!excl_q || hexokay_q);

  // Reservation updates for the data phase finishing this cycle.
  always_comb begin
    monValid_d = monValid_q;
    monWord_d  = monWord_q;
    if (state_q == RDATA && excl_q && legal_q) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (id_q == IDW'(i)) begin
          monValid_d[i] = 1'b1;
          monWord_d[i]  = word_q;
        end
      end
    end else if (state_q == WDATA) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (commit && monWord_q[i] == word_q)
          monValid_d[i] = 1'b0;
        else if (!commit && legal_q && id_q == IDW'(i))
          monValid_d[i] = 1'b0;
      end
    end
  end

  // Exclusive-write success is judged against the reservations as they will
  // stand after the current data phase, so back-to-back LR then SC works.
  always_comb begin
    exclOkNew = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (legalNew && idNew == IDW'(i))
        exclOkNew = monValid_d[i] && (monWord_d[i] == wordNew);
    end
  end

  // Next state, RAM read issue, and the next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    rdIssue = 1'b0;
    rdWord  = wordNew;
    case (state_q)
      IDLE, WDATA, RDATA, ERR2: begin
        state_d = IDLE;
        if (accept) begin
          if (addrErr)
            state_d = ERR1;
          else if (ahbls.ahbls_hwrite)
            state_d = WDATA;
          else if (state_q == WDATA)
            state_d = RSTALL;
          else begin
            state_d = RDATA;
            rdIssue = 1'b1;
          end
        end
      end
      RSTALL: begin
        state_d = RDATA;
        rdIssue = 1'b1;
        rdWord  = word_q;
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase

    hreadyResp_d = !(state_d == RSTALL || state_d == ERR1);
    hresp_d      = (state_d == ERR1 || state_d == ERR2);
    hexokay_d    = 1'b0;
    if (state_d == RDATA)
      hexokay_d = (state_q == RSTALL) ? (excl_q && legal_q) : (ahbls.ahbls_hexcl && legalNew);
    else if (state_d == WDATA)
      hexokay_d = ahbls.ahbls_hexcl && exclOkNew;
  end

  // FSM, captured address phase, registered outputs and reservation table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_q       <= '0;
      lanes_q      <= '0;
      excl_q       <= 1'b0;
      legal_q      <= 1'b0;
      id_q         <= '0;
      hreadyResp_q <= 1'b1;
      hresp_q      <= 1'b0;
      hexokay_q    <= 1'b0;
      monValid_q   <= '0;
      for (int i = 0; i < N_MASTERS; i++) monWord_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      hreadyResp_q <= hreadyResp_d;
      hresp_q      <= hresp_d;
      hexokay_q    <= hexokay_d;
      monValid_q   <= monValid_d;
      monWord_q    <= monWord_d;
      if (accept) begin
        word_q  <= wordNew;
        lanes_q <= lanesNew;
        excl_q  <= ahbls.ahbls_hexcl;
        legal_q <= legalNew;
        id_q    <= idNew;
      end
    end
  end

  // RAM array: per-lane write during a committing write data phase.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes_q[b]) mem[word_q][8*b +: 8] <= ahbls.ahbls_hwdata[8*b +: 8];
      end
    end
  end

  // RAM read port; the output only moves when entering RDATA, so it holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rdata_q <= '0;
    else if (rdIssue)
      rdata_q <= mem[rdWord];
  end

  assign ahbls.ahbls_hready_resp = hreadyResp_q;
  assign ahbls.ahbls_hresp       = hresp_q;
  assign ahbls.ahbls_hexokay     = hexokay_q;
  assign ahbls.ahbls_hrdata      = rdata_q;

endmodule

// File: tb/tb_ahbl_excl_sram_slave.sv
// Scoreboard bench for ahbl_excl_sram_slave: each scenario queues transfers,
// a reference model predicts the response of every transfer as it is queued,
// and the pipelined driver collects what the slave actually returned.
module tb_ahbl_excl_sram_slave;

  localparam int          DEPTH = 1024;
  localparam int          NM    = 4;
  localparam logic [31:0] BASE  = 32'h0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        excl;
    logic [7:0]  mst;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    int          waits;
    logic        firstResp;
    logic        resp;
    logic        exokay;
    logic [31:0] rdata;
    logic        checkData;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checksTotal = 0;
  int   checksPassed = 0;

  xfer_t seqQ[$];
  res_t  expQ[$];
  res_t  obsQ[$];

  logic [31:0] modelMem [int];
  bit          resValid [NM];
  int          resWord  [NM];
  bit          prevWrite;

  always #5 clk = ~clk;

  ahbl_excl_sram_slave_if #(.W_ADDR(32), .W_DATA(32)) bus ();
  assign bus.ahbls_hready = bus.ahbls_hready_resp;

  ahbl_excl_sram_slave #(
    .W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .N_MASTERS(NM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ahbls(bus.slave)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clearSeq();
    seqQ.delete();
    prevWrite = 1'b0;
  endtask

  // Queue one transfer and push the model's prediction for it.
  task automatic addXfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic excl, input logic [7:0] mst, input logic [31:0] wdata);
    xfer_t       t;
    res_t        e;
    logic [31:0] off, cur;
    logic [3:0]  lanes;
    int          word;
    bit          err, legal, ok;
    t = '{wr, addr, size, excl, mst, wdata};
    seqQ.push_back(t);
    e = '{default: 0};
    off = addr - BASE;
    err = (size > 3'd2) || (size == 3'd1 && addr[0]) ||
          (size == 3'd2 && addr[1:0] != 2'b00) || ((off >> 2) >= DEPTH);
    legal = (mst < NM);
    if (err) begin
      e.waits = 1; e.firstResp = 1'b1; e.resp = 1'b1;
      prevWrite = 1'b0;
    end else begin
      word = int'(off >> 2);
      if (!wr) begin
        e.waits = prevWrite ? 1 : 0;
        e.checkData = modelMem.exists(word);
        if (e.checkData) e.rdata = modelMem[word];
        if (excl && legal) begin
          e.exokay = 1'b1;
          resValid[mst] = 1'b1;
          resWord[mst] = word;
        end
        prevWrite = 1'b0;
      end else begin
        ok = !excl || (legal && resValid[mst] && resWord[mst] == word);
        e.exokay = excl && ok;
        if (ok) begin
          case (size)
            3'd0:    lanes = 4'b0001 << addr[1:0];
            3'd1:    lanes = addr[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
          endcase
          cur = modelMem.exists(word) ? modelMem[word] : 32'h0;
          for (int b = 0; b < 4; b++) if (lanes[b]) cur[8*b +: 8] = wdata[8*b +: 8];
          modelMem[word] = cur;
          for (int i = 0; i < NM; i++) if (resWord[i] == word) resValid[i] = 1'b0;
        end else if (legal) begin
          resValid[mst] = 1'b0;
        end
        prevWrite = 1'b1;
      end
    end
    expQ.push_back(e);
  endtask

  // Pipelined AHB-Lite driver: address phase of transfer k overlaps the data
  // phase of k-1; each completed data phase is pushed to obsQ.
  task automatic runSeq();
    xfer_t dp;
    res_t  o;
    bit    dpActive = 1'b0;
    bit    ready;
    int    k = 0;
    int    waits = 0;
    logic  firstResp = 1'b0;
    int    guard = 0;
    while ((k < seqQ.size() || dpActive) && guard < 20 * seqQ.size() + 20) begin
      if (k < seqQ.size()) begin
        bus.ahbls_htrans  = 2'b10;
        bus.ahbls_hwrite  = seqQ[k].wr;
        bus.ahbls_haddr   = seqQ[k].addr;
        bus.ahbls_hsize   = seqQ[k].size;
        bus.ahbls_hexcl   = seqQ[k].excl;
        bus.ahbls_hmaster = seqQ[k].mst;
      end else begin
        bus.ahbls_htrans = 2'b00;
        bus.ahbls_hexcl  = 1'b0;
      end
      bus.ahbls_hwdata = dpActive ? dp.wdata : 32'h0;
      @(negedge clk);
      ready = bus.ahbls_hready_resp;
      if (dpActive) begin
        if (!ready) begin
          if (waits == 0) firstResp = bus.ahbls_hresp;
          waits++;
        end else begin
          o = '{waits, firstResp, bus.ahbls_hresp, bus.ahbls_hexokay, bus.ahbls_hrdata, 1'b0};
          obsQ.push_back(o);
          dpActive = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      if (ready && k < seqQ.size()) begin
        dp = seqQ[k];
        dpActive = 1'b1;
        waits = 0;
        firstResp = 1'b0;
        k++;
      end
      guard++;
    end
    bus.ahbls_htrans = 2'b00;
    bus.ahbls_hexcl  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checksTotal++;
    if (bus.ahbls_hready_resp !== 1'b1) $display("FAIL reset hready_resp: got %b expected 1", bus.ahbls_hready_resp);
    else checksPassed++;
    checksTotal++;
    if (bus.ahbls_hresp !== 1'b0) $display("FAIL reset hresp: got %b expected 0", bus.ahbls_hresp);
    else checksPassed++;
    checksTotal++;
    if (bus.ahbls_hexokay !== 1'b0) $display("FAIL reset hexokay: got %b expected 0", bus.ahbls_hexokay);
    else checksPassed++;
    checksTotal++;
    if (bus.ahbls_hrdata !== 32'h0) $display("FAIL reset hrdata: got %h expected 0", bus.ahbls_hrdata);
    else checksPassed++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    res_t e, o;
    clearSeq();
    addXfer(1'b1, 32'h10, 3'd2, 1'b0, 8'd0, 32'hDEADBEEF);
    addXfer(1'b0, 32'h10, 3'd2, 1'b0, 8'd0, 32'h0);
    runSeq();
    checksTotal++;
    if (obsQ.size() != expQ.size()) $display("FAIL b2b count: got %0d expected %0d", obsQ.size(), expQ.size());
    else checksPassed++;
    for (int i = 0; expQ.size() > 0 && obsQ.size() > 0; i++) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      checksTotal++;
      if (o.waits !== e.waits) $display("FAIL b2b[%0d] waits: got %0d expected %0d", i, o.waits, e.waits);
      else checksPassed++;
      checksTotal++;
      if (o.resp !== e.resp || o.exokay !== e.exokay)
        $display("FAIL b2b[%0d] resp/exokay: got %b/%b expected %b/%b", i, o.resp, o.exokay, e.resp, e.exokay);
      else checksPassed++;
      if (e.checkData) begin
        checksTotal++;
        if (o.rdata !== e.rdata) $display("FAIL b2b[%0d] hrdata: got %h expected %h", i, o.rdata, e.rdata);
        else checksPassed++;
      end
    end
    expQ.delete(); obsQ.delete();
  endtask

  task automatic test_byte_lanes_error();
    res_t e, o;
    clearSeq();
    addXfer(1'b1, 32'h10, 3'd2, 1'b0, 8'd0, 32'h11223344);
    addXfer(1'b1, 32'h13, 3'd0, 1'b0, 8'd0, 32'hAB000000);
    addXfer(1'b0, 32'h10, 3'd2, 1'b0, 8'd0, 32'h0);
    addXfer(1'b0, 32'h11, 3'd1, 1'b0, 8'd0, 32'h0);
    addXfer(1'b1, 32'h22, 3'd1, 1'b0, 8'd0, 32'h5A5A0000);
    addXfer(1'b0, 32'h20, 3'd2, 1'b0, 8'd0, 32'h0);
    addXfer(1'b0, 32'h20, 3'd3, 1'b0, 8'd0, 32'h0);
    runSeq();
    checksTotal++;
    if (obsQ.size() != expQ.size()) $display("FAIL lanes count: got %0d expected %0d", obsQ.size(), expQ.size());
    else checksPassed++;
    for (int i = 0; expQ.size() > 0 && obsQ.size() > 0; i++) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      checksTotal++;
      if (o.waits !== e.waits) $display("FAIL lanes[%0d] waits: got %0d expected %0d", i, o.waits, e.waits);
      else checksPassed++;
      checksTotal++;
      if (o.resp !== e.resp || o.exokay !== e.exokay)
        $display("FAIL lanes[%0d] resp/exokay: got %b/%b expected %b/%b", i, o.resp, o.exokay, e.resp, e.exokay);
      else checksPassed++;
      if (e.waits > 0) begin
        checksTotal++;
        if (o.firstResp !== e.firstResp) $display("FAIL lanes[%0d] stall hresp: got %b expected %b", i, o.firstResp, e.firstResp);
        else checksPassed++;
      end
      if (e.checkData) begin
        checksTotal++;
        if (o.rdata !== e.rdata) $display("FAIL lanes[%0d] hrdata: got %h expected %h", i, o.rdata, e.rdata);
        else checksPassed++;
      end
    end
    expQ.delete(); obsQ.delete();
  endtask

  task automatic test_excl_single();
    res_t e, o;
    clearSeq();
    addXfer(1'b1, 32'h40, 3'd2, 1'b0, 8'd1, 32'hCAFE0001);
    addXfer(1'b0, 32'h40, 3'd2, 1'b1, 8'd1, 32'h0);
    addXfer(1'b1, 32'h40, 3'd2, 1'b1, 8'd1, 32'h00000005);
    addXfer(1'b0, 32'h40, 3'd2, 1'b0, 8'd1, 32'h0);
    addXfer(1'b1, 32'h40, 3'd2, 1'b1, 8'd1, 32'h00000077);
    addXfer(1'b0, 32'h40, 3'd2, 1'b0, 8'd1, 32'h0);
    runSeq();
    checksTotal++;
    if (obsQ.size() != expQ.size()) $display("FAIL excl1 count: got %0d expected %0d", obsQ.size(), expQ.size());
    else checksPassed++;
    for (int i = 0; expQ.size() > 0 && obsQ.size() > 0; i++) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      checksTotal++;
      if (o.waits !== e.waits) $display("FAIL excl1[%0d] waits: got %0d expected %0d", i, o.waits, e.waits);
      else checksPassed++;
      checksTotal++;
      if (o.resp !== e.resp || o.exokay !== e.exokay)
        $display("FAIL excl1[%0d] resp/exokay: got %b/%b expected %b/%b", i, o.resp, o.exokay, e.resp, e.exokay);
      else checksPassed++;
      if (e.checkData) begin
        checksTotal++;
        if (o.rdata !== e.rdata) $display("FAIL excl1[%0d] hrdata: got %h expected %h", i, o.rdata, e.rdata);
        else checksPassed++;
      end
    end
    expQ.delete(); obsQ.delete();
  endtask

  task automatic test_excl_contention();
    res_t e, o;
    clearSeq();
    addXfer(1'b1, 32'h80, 3'd2, 1'b0, 8'd0, 32'h00000080);
    addXfer(1'b0, 32'h80, 3'd2, 1'b1, 8'd0, 32'h0);
    addXfer(1'b0, 32'h80, 3'd2, 1'b1, 8'd2, 32'h0);
    addXfer(1'b1, 32'h80, 3'd2, 1'b1, 8'd0, 32'h11110000);
    addXfer(1'b1, 32'h80, 3'd2, 1'b1, 8'd2, 32'h22220000);
    addXfer(1'b0, 32'h80, 3'd2, 1'b0, 8'd2, 32'h0);
    runSeq();
    checksTotal++;
    if (obsQ.size() != expQ.size()) $display("FAIL contend count: got %0d expected %0d", obsQ.size(), expQ.size());
    else checksPassed++;
    for (int i = 0; expQ.size() > 0 && obsQ.size() > 0; i++) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      checksTotal++;
      if (o.resp !== e.resp || o.exokay !== e.exokay)
        $display("FAIL contend[%0d] resp/exokay: got %b/%b expected %b/%b", i, o.resp, o.exokay, e.resp, e.exokay);
      else checksPassed++;
      if (e.checkData) begin
        checksTotal++;
        if (o.rdata !== e.rdata) $display("FAIL contend[%0d] hrdata: got %h expected %h", i, o.rdata, e.rdata);
        else checksPassed++;
      end
    end
    expQ.delete(); obsQ.delete();
  endtask

  task automatic test_excl_clear();
    res_t e, o;
    clearSeq();
    addXfer(1'b1, 32'h100, 3'd2, 1'b0, 8'd3, 32'h00000100);
    addXfer(1'b0, 32'h100, 3'd2, 1'b1, 8'd3, 32'h0);
    addXfer(1'b1, 32'h100, 3'd0, 1'b0, 8'd0, 32'h000000EE);
    addXfer(1'b1, 32'h100, 3'd2, 1'b1, 8'd3, 32'h33333333);
    addXfer(1'b0, 32'h100, 3'd2, 1'b1, 8'd7, 32'h0);
    addXfer(1'b1, 32'h100, 3'd2, 1'b1, 8'd7, 32'h77777777);
    addXfer(1'b0, 32'h100, 3'd2, 1'b0, 8'd0, 32'h0);
    runSeq();
    checksTotal++;
    if (obsQ.size() != expQ.size()) $display("FAIL clear count: got %0d expected %0d", obsQ.size(), expQ.size());
    else checksPassed++;
    for (int i = 0; expQ.size() > 0 && obsQ.size() > 0; i++) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      checksTotal++;
      if (o.resp !== e.resp || o.exokay !== e.exokay)
        $display("FAIL clear[%0d] resp/exokay: got %b/%b expected %b/%b", i, o.resp, o.exokay, e.resp, e.exokay);
      else checksPassed++;
      if (e.checkData) begin
        checksTotal++;
        if (o.rdata !== e.rdata) $display("FAIL clear[%0d] hrdata: got %h expected %h", i, o.rdata, e.rdata);
        else checksPassed++;
      end
    end
    expQ.delete(); obsQ.delete();
  endtask

  task automatic test_range_and_reset();
    res_t e, o;
    clearSeq();
    addXfer(1'b1, 32'h300, 3'd2, 1'b0, 8'd1, 32'h00000300);
    addXfer(1'b0, 32'h300, 3'd2, 1'b1, 8'd1, 32'h0);
    addXfer(1'b0, BASE + 32'(4 * DEPTH), 3'd2, 1'b1, 8'd1, 32'h0);
    addXfer(1'b1, 32'h300, 3'd2, 1'b1, 8'd1, 32'h00000301);
    addXfer(1'b0, 32'h300, 3'd2, 1'b0, 8'd1, 32'h0);
    addXfer(1'b1, 32'h200, 3'd2, 1'b0, 8'd0, 32'h12345678);
    addXfer(1'b0, 32'h300, 3'd2, 1'b0, 8'd1, 32'h0);
    runSeq();

    // Start a write to 0x200 and pull reset while its data phase is live.
    bus.ahbls_htrans  = 2'b10;
    bus.ahbls_hwrite  = 1'b1;
    bus.ahbls_haddr   = 32'h200;
    bus.ahbls_hsize   = 3'd2;
    bus.ahbls_hexcl   = 1'b0;
    bus.ahbls_hmaster = 8'd0;
    @(posedge clk);
    #1;
    bus.ahbls_htrans = 2'b00;
    bus.ahbls_hwdata = 32'hFFFFFFFF;
    rst_n = 1'b0;
    #1;
    checksTotal++;
    if (bus.ahbls_hready_resp !== 1'b1 || bus.ahbls_hresp !== 1'b0)
      $display("FAIL midreset ready/resp: got %b/%b expected 1/0", bus.ahbls_hready_resp, bus.ahbls_hresp);
    else checksPassed++;
    checksTotal++;
    if (bus.ahbls_hexokay !== 1'b0 || bus.ahbls_hrdata !== 32'h0)
      $display("FAIL midreset exokay/hrdata: got %b/%h expected 0/00000000", bus.ahbls_hexokay, bus.ahbls_hrdata);
    else checksPassed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NM; i++) resValid[i] = 1'b0;
    @(posedge clk);
    #1;

    clearSeq();
    addXfer(1'b0, 32'h200, 3'd2, 1'b0, 8'd0, 32'h0);
    runSeq();
    checksTotal++;
    if (obsQ.size() != expQ.size()) $display("FAIL range count: got %0d expected %0d", obsQ.size(), expQ.size());
    else checksPassed++;
    for (int i = 0; expQ.size() > 0 && obsQ.size() > 0; i++) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      checksTotal++;
      if (o.waits !== e.waits) $display("FAIL range[%0d] waits: got %0d expected %0d", i, o.waits, e.waits);
      else checksPassed++;
      checksTotal++;
      if (o.resp !== e.resp || o.exokay !== e.exokay)
        $display("FAIL range[%0d] resp/exokay: got %b/%b expected %b/%b", i, o.resp, o.exokay, e.resp, e.exokay);
      else checksPassed++;
      if (e.waits > 0) begin
        checksTotal++;
        if (o.firstResp !== e.firstResp) $display("FAIL range[%0d] stall hresp: got %b expected %b", i, o.firstResp, e.firstResp);
        else checksPassed++;
      end
      if (e.checkData) begin
        checksTotal++;
        if (o.rdata !== e.rdata) $display("FAIL range[%0d] hrdata: got %h expected %h", i, o.rdata, e.rdata);
        else checksPassed++;
      end
    end
    expQ.delete(); obsQ.delete();
  endtask

  initial begin
    bus.ahbls_htrans    = 2'b00;
    bus.ahbls_hwrite    = 1'b0;
    bus.ahbls_haddr     = 32'h0;
    bus.ahbls_hsize     = 3'd2;
    bus.ahbls_hburst    = 3'd0;
    bus.ahbls_hprot     = 4'h3;
    bus.ahbls_hmastlock = 1'b0;
    bus.ahbls_hwdata    = 32'h0;
    bus.ahbls_hexcl     = 1'b0;
    bus.ahbls_hmaster   = 8'd0;
    for (int i = 0; i < NM; i++) begin
      resValid[i] = 1'b0;
      resWord[i]  = 0;
    end
    prevWrite = 1'b0;

    test_reset();
    test_back_to_back();
    test_byte_lanes_error();
    test_excl_single();
    test_excl_contention();
    test_excl_clear();
    test_range_and_reset();

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/ahbl_excl_sram_slave.md
Name: ahbl_excl_sram_slave

Overview:
- AHB-Lite responder: the slave end that the fabric arbiters drive.
- Terminates one AHB-Lite slave port onto an internal single-port synchronous word RAM.
- Implements the exclusive-access responder side: a per-master reservation monitor that consumes hexcl/hmaster and drives hexokay.
- Serves as shared main/scratch memory for multi-hart LR/SC testing.

Parameters:
- W_ADDR, 32, address width.
- W_DATA, 32, data width; fixed at 32.
- DEPTH, 1024, RAM size in 32-bit words; power of two.
- BASE_ADDR, 32'h0, byte address of word 0.
- N_MASTERS, 4, number of reservation entries, indexed by hmaster[$clog2(N_MASTERS)-1:0].

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset, asynchronous, active-low.
- ahbls_hready, input, 1, bus ready; an address phase is accepted when htrans[1] && hready.
- ahbls_hready_resp, output, 1, slave ready.
- ahbls_hresp, output, 1, 1 = ERROR.
- ahbls_haddr, input, W_ADDR, byte address.
- ahbls_hwrite, input, 1, write.
- ahbls_htrans, input, 2, transfer type.
- ahbls_hsize, input, 3, transfer size; 0, 1 and 2 are legal.
- ahbls_hburst, input, 3, ignored.
- ahbls_hprot, input, 4, ignored.
- ahbls_hmastlock, input, 1, ignored.
- ahbls_hwdata, input, W_DATA, write data, valid in data phase.
- ahbls_hrdata, output, W_DATA, read data.
- ahbls_hexcl, input, 1, exclusive transfer.
- ahbls_hmaster, input, 8, master ID.
- ahbls_hexokay, output, 1, exclusive success, valid in the final data-phase cycle.

Behaviour:
- Reset values: hready_resp=1, hresp=0, hexokay=0, hrdata=0. All reservations invalid; FSM=IDLE. RAM contents are not reset.
- Reset mid-transfer aborts the transfer. A pending write is not committed.
- Address-phase capture on acceptance: word index, byte lanes, hwrite, hexcl, master ID.
- Byte lanes: decoded from hsize and haddr[1:0].
- Error conditions, detected at address phase:
  - hsize>2;
  - misaligned access (hsize=1 with haddr[0]=1; hsize=2 with haddr[1:0]!=0);
  - (haddr-BASE_ADDR)>>2 >= DEPTH.
- FSM states: IDLE, WDATA, RDATA, RSTALL, ERR1, ERR2.
- IDLE: no data phase is pending.
  - accepted error -> ERR1;
  - accepted write -> WDATA;
  - accepted read -> RDATA, with the RAM read issued this same cycle (port free).
- WDATA: hready_resp=1, zero wait states.
  - The RAM write (per-lane) is committed this cycle using hwdata.
  - Exception: a failed exclusive write commits nothing.
  - A read accepted in this cycle cannot use the port -> RSTALL. The read is issued next cycle.
- RDATA: hready_resp=1; hrdata = RAM output.
  - Next state is chosen from the new address phase, as from IDLE.
- RSTALL: hready_resp=0; the RAM read is issued; next state RDATA.
  - Read latency after a write data phase is therefore 2 cycles instead of 1.
- ERR1: hready_resp=0, hresp=1; next state ERR2.
- ERR2: hready_resp=1, hresp=1. A transfer accepted here is processed as from IDLE.
- hrdata holds its last value outside RDATA.
- Exclusive monitor, per entry: valid bit + word index. All updates occur in the final data-phase cycle, so at most one update happens per cycle.
  - Exclusive read, legal ID: set entry[ID] = {1, word}; hexokay=1.
  - Exclusive write, success condition: legal ID && entry[ID].valid && word match. On success: commit the write, hexokay=1, clear every entry whose word matches (including ID's entry). On failure: suppress the write, hexokay=0, hresp=0 (OKAY), and clear entry[ID].
  - Non-exclusive write: commit the write, and clear every entry whose word matches, regardless of byte lanes.
  - hmaster >= N_MASTERS: exclusive reads return data with hexokay=0; exclusive writes always fail.
  - Errored transfers do not touch the monitor; hexokay=0.
  - Non-exclusive transfers: hexokay=0.
- Simultaneous events:
  - A master's exclusive read re-arms its entry to the new word.
  - A write by master A clears B's reservation even if A holds a reservation on the same word.

Test Plan:
1. Write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> write has zero waits; read data phase shows hready_resp=0 for 1 cycle, then hrdata=0xDEADBEEF.
2. Byte write 0xAB to 0x13 after word 0x11223344 at 0x10 -> read of 0x10 returns 0xAB223344. Halfword read of 0x11 -> ERR1/ERR2 two-cycle error, hresp=1 in both cycles.
3. Master 1: exclusive read 0x40, then exclusive write 0x5 to 0x40 -> hexokay=1 on both; memory=0x5. A second exclusive write to 0x40 -> hexokay=0, memory unchanged.
4. Masters 0 and 2 both exclusive-read 0x80; master 0 exclusive-writes 0x80 -> succeeds; master 2's exclusive write then fails with hexokay=0, value unchanged.
5. Master 3 exclusive-reads 0x100; master 0 does a plain write to 0x100 -> master 3's exclusive write fails. hmaster=7 exclusive write always fails.
6. Read of BASE_ADDR+4*DEPTH -> two-cycle ERROR, monitor unchanged. Assert rst_n during a WDATA cycle -> outputs at reset values, RAM word unmodified.
